// File: rtl/alarm_pkg.sv
// Shared types and field limits for the alarm-time controller.
package alarm_pkg;

    typedef enum logic [2:0] {
        ST_NORMAL  = 3'd0,
        ST_SET_HR  = 3'd1,
        ST_SET_MIN = 3'd2,
        ST_RING    = 3'd3,
        ST_SNOOZE  = 3'd4
    } alarm_state_t;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;

endpackage

// File: rtl/alarm_ctrl_if.sv
// Time inputs, buttons and display/ring outputs of the alarm controller.
interface alarm_ctrl_if;
    import alarm_pkg::*;

    logic              tick_1s;
    logic [HOUR_W-1:0] cur_hour;
    logic [MIN_W-1:0]  cur_min;
    logic [5:0]        cur_sec;
    logic              alarm_en;
    logic              btn_mode;
    logic              btn_inc;
    logic              btn_snooze;
    logic [HOUR_W-1:0] alm_hour;
    logic [MIN_W-1:0]  alm_min;
    logic              blank_hour;
    logic              blank_min;
    logic              edit_active;
    logic              ringing;

    modport master (
        output tick_1s, cur_hour, cur_min, cur_sec, alarm_en,
               btn_mode, btn_inc, btn_snooze,
        input  alm_hour, alm_min, blank_hour, blank_min, edit_active, ringing
    );

    modport slave (
        input  tick_1s, cur_hour, cur_min, cur_sec, alarm_en,
               btn_mode, btn_inc, btn_snooze,
        output alm_hour, alm_min, blank_hour, blank_min, edit_active, ringing
    );

endinterface

// File: rtl/alarm_ctrl_blink_gen.sv
// Blink phase generator: phase 0 = visible, toggles every CLK_HZ/(2*BLINK_HZ) cycles.
module blink_gen #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int BLINK_HZ = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic restart,
    output logic phase
);

    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (!enable || restart) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == CW'(HALF - 1)) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm-time controller: alarm setting with blinking edit field, trigger, ring, snooze.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BLINK_HZ   = 2,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    alarm_ctrl_if.slave  bus
);

    localparam logic [2:0] S_NORMAL  = ST_NORMAL;
    localparam logic [2:0] S_SET_HR  = ST_SET_HR;
    localparam logic [2:0] S_SET_MIN = ST_SET_MIN;
    localparam logic [2:0] S_RING    = ST_RING;
    localparam logic [2:0] S_SNOOZE  = ST_SNOOZE;

    localparam int SNZ_TICKS = SNOOZE_MIN * 60;
    localparam int RW = $clog2(RING_SEC + 1);
    localparam int SW = $clog2(SNZ_TICKS + 1);

    logic [2:0]        state, state_nx;
    logic [HOUR_W-1:0] alm_hour, hour_nx;
    logic [MIN_W-1:0]  alm_min, min_nx;
    logic [RW-1:0]     ring_cnt, ring_nx;
    logic [SW-1:0]     snz_cnt, snz_nx;
    logic              inc_hit, trigger, set_nx, phase;

    assign trigger = bus.alarm_en && bus.tick_1s && (bus.cur_hour == alm_hour) &&
                     (bus.cur_min == alm_min) && (bus.cur_sec == '0);

    always_comb begin
        state_nx = state;
        hour_nx  = alm_hour;
        min_nx   = alm_min;
        ring_nx  = ring_cnt;
        snz_nx   = snz_cnt;
        inc_hit  = 1'b0;
        case (state)
            S_NORMAL: begin
                if (bus.btn_mode) begin
                    state_nx = S_SET_HR;
                end else if (trigger) begin
                    state_nx = S_RING;
                    ring_nx  = '0;
                end
            end
            S_SET_HR: begin
                if (bus.btn_mode) begin
                    state_nx = S_SET_MIN;
                end else if (bus.btn_inc) begin
                    hour_nx = (alm_hour == HOUR_MAX) ? '0 : alm_hour + 1'b1;
                    inc_hit = 1'b1;
                end
            end
            S_SET_MIN: begin
                if (bus.btn_mode) begin
                    state_nx = S_NORMAL;
                end else if (bus.btn_inc) begin
                    min_nx  = (alm_min == MIN_MAX) ? '0 : alm_min + 1'b1;
                    inc_hit = 1'b1;
                end
            end
            S_RING: begin
                // Disable beats stop, stop beats snooze, any button beats the tick.
                if (!bus.alarm_en || bus.btn_mode) begin
                    state_nx = S_NORMAL;
                end else if (bus.btn_snooze) begin
                    state_nx = S_SNOOZE;
                    snz_nx   = '0;
                end else if (bus.tick_1s) begin
                    if (ring_cnt == RW'(RING_SEC - 1)) state_nx = S_NORMAL;
                    else                                ring_nx  = ring_cnt + 1'b1;
                end
            end
            S_SNOOZE: begin
                if (!bus.alarm_en || bus.btn_mode) begin
                    state_nx = S_NORMAL;
                end else if (bus.tick_1s) begin
                    if (snz_cnt == SW'(SNZ_TICKS - 1)) begin
                        state_nx = S_RING;
                        ring_nx  = '0;
                    end else begin
                        snz_nx = snz_cnt + 1'b1;
                    end
                end
            end
            default: state_nx = S_NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_NORMAL;
            alm_hour <= '0;
            alm_min  <= '0;
            ring_cnt <= '0;
            snz_cnt  <= '0;
        end else begin
            state    <= state_nx;
            alm_hour <= hour_nx;
            alm_min  <= min_nx;
            ring_cnt <= ring_nx;
            snz_cnt  <= snz_nx;
        end
    end

    assign set_nx = (state_nx == S_SET_HR) || (state_nx == S_SET_MIN);

    blink_gen #(
        .CLK_HZ  (CLK_HZ),
        .BLINK_HZ(BLINK_HZ)
    ) u_blink (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (set_nx),
        .restart(inc_hit || (set_nx && (state_nx != state))),
        .phase  (phase)
    );

    // Outputs decode flops only, so they change cleanly on the clock edge.
    assign bus.alm_hour    = alm_hour;
    assign bus.alm_min     = alm_min;
    assign bus.blank_hour  = phase && (state == S_SET_HR);
    assign bus.blank_min   = phase && (state == S_SET_MIN);
    assign bus.edit_active = (state == S_SET_HR) || (state == S_SET_MIN);
    assign bus.ringing     = (state == S_RING);

endmodule
